// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the carry-lookahead adder.
// Captures each accepted beat with derived {N,Z,C,V} flags into a 2-entry skid FIFO
// (valid/ready on both sides) and keeps a saturating count of signed-overflow beats.
// Optional feature: define ALU_SAT_EN to saturate the stored result on overflow.
module alu_result_stage #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [BITS-1:0]     i_result,
    input  logic                i_cout,
    input  logic                i_a_msb,
    input  logic                i_b_msb,
    input  logic                i_sub,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [BITS-1:0]     o_result,
    output logic [3:0]          o_flags,
    input  logic                i_clr_cnt,
    output logic [CNT_BITS-1:0] o_ovf_cnt
);

    localparam logic [CNT_BITS-1:0] CntOne = 1;
    localparam logic [CNT_BITS-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e              state_q;
    logic                ready_en_q;
    logic [BITS-1:0]     head_result_q;
    logic [3:0]          head_flags_q;
    logic [BITS-1:0]     tail_result_q;
    logic [3:0]          tail_flags_q;
    logic [CNT_BITS-1:0] ovf_cnt_q;

    logic                ready;
    logic                accept;
    logic                emit;
    logic                flag_n;
    logic                flag_z;
    logic                flag_c;
    logic                flag_v;
    logic [BITS-1:0]     store_result;
    logic [3:0]          store_flags;

    // ready_en_q keeps o_ready low while in reset and for the first cycle after release.
    assign ready    = ready_en_q & (state_q != StFull);
    assign accept   = i_valid & ready;
    assign emit     = (state_q != StEmpty) & i_ready;

    assign o_ready   = ready;
    assign o_valid   = (state_q != StEmpty);
    assign o_result  = head_result_q;
    assign o_flags   = head_flags_q;
    assign o_ovf_cnt = ovf_cnt_q;

    // Flags and stored value for the incoming beat; V and C come from the raw adder outputs.
    always_comb begin
        flag_v       = (i_a_msb == i_b_msb) & (i_result[BITS-1] != i_a_msb);
        flag_c       = i_cout ^ i_sub;
        store_result = i_result;
`ifdef ALU_SAT_EN
        if (flag_v) begin
            store_result = i_a_msb ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end
`endif
        flag_n      = store_result[BITS-1];
        flag_z      = (store_result == '0);
        store_flags = {flag_n, flag_z, flag_c, flag_v};
    end

    // FIFO control and storage: head drives the outputs, tail is the skid slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StEmpty;
            ready_en_q    <= 1'b0;
            head_result_q <= '0;
            head_flags_q  <= '0;
            tail_result_q <= '0;
            tail_flags_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_result_q <= store_result;
                        head_flags_q  <= store_flags;
                        state_q       <= StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        head_result_q <= store_result;
                        head_flags_q  <= store_flags;
                    end else if (accept) begin
                        tail_result_q <= store_result;
                        tail_flags_q  <= store_flags;
                        state_q       <= StFull;
                    end else if (emit) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (emit) begin
                        head_result_q <= tail_result_q;
                        head_flags_q  <= tail_flags_q;
                        state_q       <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // Saturating overflow counter; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_cnt_q <= '0;
        end else if (i_clr_cnt) begin
            ovf_cnt_q <= '0;
        end else if (accept && flag_v && (ovf_cnt_q != CntMax)) begin
            ovf_cnt_q <= ovf_cnt_q + CntOne;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table for flag/result rules plus
// hand-written sequences for reset, backpressure, streaming and the overflow counter.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] result_in;
    logic       cout_in;
    logic       a_msb_in;
    logic       b_msb_in;
    logic       sub_in;
    logic       valid_out;
    logic       ready_in;
    logic [7:0] result_out;
    logic [3:0] flags_out;
    logic       clr_cnt;
    logic [7:0] ovf_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_stage #(
        .BITS     (8),
        .CNT_BITS (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid_in),
        .o_ready   (ready_out),
        .i_result  (result_in),
        .i_cout    (cout_in),
        .i_a_msb   (a_msb_in),
        .i_b_msb   (b_msb_in),
        .i_sub     (sub_in),
        .o_valid   (valid_out),
        .i_ready   (ready_in),
        .o_result  (result_out),
        .o_flags   (flags_out),
        .i_clr_cnt (clr_cnt),
        .o_ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       a_msb;
        logic       b_msb;
        logic       sub;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [7:0] r, input logic c, input logic a, input logic b,
                            input logic s);
        result_in = r;
        cout_in   = c;
        a_msb_in  = a;
        b_msb_in  = b;
        sub_in    = s;
    endtask

    initial begin
        // res, cout, a, b, sub, expected result, expected {N,Z,C,V}, expected count
`ifdef ALU_SAT_EN
        vecs[0] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 4'b0001, 8'd1}; // 7F+01
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 4'b1011, 8'd2}; // 80+80
        vecs[5] = '{8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 4'b1001, 8'd3}; // 80-01
`else
        vecs[0] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 4'b1001, 8'd1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0111, 8'd2};
        vecs[5] = '{8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 4'b0001, 8'd3};
`endif
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'b0100, 8'd1}; // 05-05
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0110, 8'd1}; // FF+01
        vecs[4] = '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 4'b1010, 8'd2}; // 03-05
        vecs[6] = '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 4'b0000, 8'd3}; // 10+20

        // Reset held with upstream valid asserted
        rst_n    = 1'b0;
        valid_in = 1'b1;
        ready_in = 1'b1;
        clr_cnt  = 1'b0;
        set_beat(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd0);
        check("rst_cnt", 32'(ovf_cnt), 32'd0);
        check("rst_result", 32'(result_out), 32'd0);
        check("rst_flags", 32'(flags_out), 32'd0);
        valid_in = 1'b0;
        rst_n    = 1'b1;
        step();
        check("post_rst_ready", 32'(ready_out), 32'd1);
        check("post_rst_valid", 32'(valid_out), 32'd0);

        // Flag/result table, one beat per vector with downstream always ready
        for (int i = 0; i < 7; i++) begin
            set_beat(vecs[i].res, vecs[i].cout, vecs[i].a_msb, vecs[i].b_msb, vecs[i].sub);
            valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'd1);
            check($sformatf("vec%0d_result", i), 32'(result_out), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_flags", i), 32'(flags_out), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_cnt", i), 32'(ovf_cnt), 32'(vecs[i].exp_cnt));
        end
        step();
        check("table_drained", 32'(valid_out), 32'd0);

        // Backpressure: two beats fill the FIFO, third is held upstream
        ready_in = 1'b0;
        valid_in = 1'b1;
        set_beat(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_ready_one", 32'(ready_out), 32'd1);
        check("bp_head_11a", 32'(result_out), 32'h11);
        set_beat(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_ready_full", 32'(ready_out), 32'd0);
        check("bp_head_11b", 32'(result_out), 32'h11);
        set_beat(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        check("bp_stall_ready", 32'(ready_out), 32'd0);
        check("bp_head_11c", 32'(result_out), 32'h11);
        check("bp_stall_valid", 32'(valid_out), 32'd1);
        ready_in = 1'b1;
        step();
        check("bp_head_22", 32'(result_out), 32'h22);
        check("bp_ready_back", 32'(ready_out), 32'd1);
        step();
        check("bp_head_33", 32'(result_out), 32'h33);
        valid_in = 1'b0;
        step();
        check("bp_drained", 32'(valid_out), 32'd0);

        // Streaming: one beat per cycle, ready never drops
        for (int i = 0; i < 10; i++) begin
            set_beat(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            valid_in = 1'b1;
            check($sformatf("stream%0d_ready", i), 32'(ready_out), 32'd1);
            step();
            check($sformatf("stream%0d_result", i), 32'(result_out), 32'(i));
            check($sformatf("stream%0d_valid", i), 32'(valid_out), 32'd1);
        end
        valid_in = 1'b0;
        step();

        // Counter saturation
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt_cleared", 32'(ovf_cnt), 32'd0);
        set_beat(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        valid_in = 1'b1;
        repeat (100) step();
        check("cnt_100", 32'(ovf_cnt), 32'd100);
        repeat (155) step();
        check("cnt_255", 32'(ovf_cnt), 32'd255);
        repeat (45) step();
        check("cnt_sat_300", 32'(ovf_cnt), 32'd255);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("cnt_clr_prio", 32'(ovf_cnt), 32'd0);
        repeat (3) step();
        check("cnt_after_clr", 32'(ovf_cnt), 32'd3);

        // Asynchronous reset in the middle of the stream
        rst_n = 1'b0;
        #2;
        check("midrst_valid", 32'(valid_out), 32'd0);
        check("midrst_cnt", 32'(ovf_cnt), 32'd0);
        check("midrst_result", 32'(result_out), 32'd0);
        check("midrst_ready", 32'(ready_out), 32'd0);
        step();
        valid_in = 1'b0;
        rst_n    = 1'b1;
        step();
        check("midrst_rel_ready", 32'(ready_out), 32'd1);
        check("midrst_rel_valid", 32'(valid_out), 32'd0);
        set_beat(8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        check("midrst_beat", 32'(result_out), 32'h42);
        check("midrst_cnt_hold", 32'(ovf_cnt), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
